grid_mem_arbiter: RTL and testbench
===================================

Name: grid_mem_arbiter

Overview:
- Shares the single-port tetris grid RAM between two requesters:
  - the game FSM (read/write; place, move and line-clear traffic)
  - the video fetch unit (read-only; scans grid cells for display)
- Video normally wins, because the display has a hard deadline. A starvation counter guarantees the game FSM a slot after a bounded run of video grants.
- Sits between the grid controller's memory mux output and the grid RAM.

Parameters:
- GRID_DEPTH, 252: number of valid grid addresses, 0..GRID_DEPTH-1. Covers 240 play cells plus 12 placement cells.
- OOR_DATA, 8'h08: data returned for out-of-range reads. Equals the border block code.
- MAX_VID_RUN, 4: maximum consecutive video grants while game_req is pending. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- game_req  in  1  game access request; held until granted
- game_we  in  1  1 = write, 0 = read
- game_addr  in  8  game address
- game_wdata  in  8  game write data
- game_gnt  out  1  access performed this cycle
- game_rvalid  out  1  game read data valid
- game_rdata  out  8  game read data
- vid_req  in  1  video read request
- vid_addr  in  8  video address
- vid_gnt  out  1  access performed this cycle
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  8  video read data
- mem_addr  out  8  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  8  RAM read data; synchronous, 1-cycle latency

Behaviour:
- Reset clears the following to 0: game_gnt, vid_gnt, game_rvalid, vid_rvalid, game_rdata, vid_rdata, mem_we, mem_addr, mem_wdata. It also clears vid_run_cnt and the read-pending flags.
- Reset mid-operation: any read in flight is dropped and no rvalid is produced after reset.
- Grant logic is combinational in cycle N:
  - at most one gnt is high in any cycle
  - mem_addr, mem_we and mem_wdata are driven from the granted requester
  - mem_we = 0 and mem_addr = 0 when neither is granted
- Arbitration:
  - Only vid_req: video granted.
  - Only game_req: game granted.
  - Both requesting: video granted unless vid_run_cnt == MAX_VID_RUN, in which case game is granted.
- vid_run_cnt:
  - Increments on each video grant while game_req = 1.
  - Clears on any game grant, and on any cycle with game_req = 0.
  - Saturates at MAX_VID_RUN.
- States: IDLE (no grant), GNT_GAME, GNT_VID. These are registered as last_owner for debug and run tracking; the next state is the combinational grant result.
- Read return:
  - A granted read in cycle N raises the requester's rvalid for exactly cycle N+1, with rdata = mem_rdata.
  - rdata holds its value when rvalid = 0.
  - Back-to-back reads give rvalid on consecutive cycles.
  - Writes never raise rvalid.
- Out-of-range address (addr >= GRID_DEPTH):
  - Grant still issues.
  - mem_we is forced to 0, so no RAM write occurs.
  - A read returns OOR_DATA at N+1 instead of mem_rdata.
- Write-then-read to the same address in consecutive cycles returns the new data (the RAM is read-after-write coherent through its 1-cycle pipeline).
- The requester must keep req, addr, we and wdata stable until the cycle in which gnt = 1. Changing them before grant is a protocol error and its result is undefined.

Optional Feature:
- Macro: GRID_ARB_LOCK_EN.
- Defined:
  - Adds input port game_lock (1 bit).
  - While game_lock = 1 and game was the last owner, video is not granted, regardless of vid_run_cnt.
  - This makes the move sequence (clear old cells, write new cells) atomic with respect to display.
  - Lock is ignored if game was not the last owner.
  - Lock is released by game_lock = 0.
- Undefined: no game_lock port; arbitration is exactly as described above.

Test Plan:
- Only game_req with game_we=1, addr=8'd17, wdata=8'h03 -> game_gnt=1 same cycle, mem_we=1, mem_addr=17. Then a game read of address 17 -> game_rvalid=1 next cycle, game_rdata=8'h03.
- vid_req and game_req held high together, MAX_VID_RUN=4 -> vid_gnt for 4 cycles, game_gnt in cycle 5, then vid_gnt resumes.
- Game write to addr=8'd252 with wdata=8'h05 -> game_gnt=1, mem_we=0. Game read of addr 8'd255 -> game_rdata=8'h08 one cycle later.
- Video reads of addresses 0,1,2 on consecutive cycles -> vid_rvalid high for 3 consecutive cycles, data in order; game_rvalid stays 0.
- Read granted, then reset asserted in cycle N+1 -> no rvalid, all outputs 0 in cycle N+1. First grant after reset release behaves normally.
- GRID_ARB_LOCK_EN defined: game write granted with game_lock=1, vid_req high for 10 cycles -> vid_gnt=0 throughout. game_lock=0 -> vid_gnt=1 the next cycle.

Source files
------------

// File: rtl/grid_mem_arbiter_if.sv
// Bus bundle between the grid controller, video fetch, arbiter and grid RAM.
// GRID_ARB_LOCK_EN adds the game_lock signal.
interface grid_mem_arbiter_if;
  logic       game_req;
  logic       game_we;
  logic [7:0] game_addr;
  logic [7:0] game_wdata;
  logic       game_gnt;
  logic       game_rvalid;
  logic [7:0] game_rdata;
  logic       vid_req;
  logic [7:0] vid_addr;
  logic       vid_gnt;
  logic       vid_rvalid;
  logic [7:0] vid_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
`ifdef GRID_ARB_LOCK_EN
  logic       game_lock;
`endif

  // Requester and RAM side of the bus.
  modport master (
    output game_req, game_we, game_addr, game_wdata,
    input  game_gnt, game_rvalid, game_rdata,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
`ifdef GRID_ARB_LOCK_EN
    , output game_lock
`endif
  );

  // Arbiter side of the bus.
  modport slave (
    input  game_req, game_we, game_addr, game_wdata,
    output game_gnt, game_rvalid, game_rdata,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
`ifdef GRID_ARB_LOCK_EN
    , input game_lock
`endif
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Arbiter sharing the single-port grid RAM between the game FSM and video
// fetch. Video wins by default; a run counter bounds how long game can wait.
// Optional macro GRID_ARB_LOCK_EN adds game_lock, which keeps video off the
// RAM while game owns it.
//
// state    | meaning
// IDLE     | no grant last cycle
// GNT_GAME | game owned the RAM last cycle (also held while locked and idle)
// GNT_VID  | video owned the RAM last cycle
module grid_mem_arbiter #(
  parameter int          GRID_DEPTH  = 252,
  parameter logic [7:0]  OOR_DATA    = 8'h08,
  parameter int          MAX_VID_RUN = 4
) (
  input logic               clk,
  input logic               reset,
  grid_mem_arbiter_if.slave bus
);

  localparam logic [8:0] DEPTH_LIM = 9'(GRID_DEPTH);
  localparam logic [3:0] MAX_RUN   = 4'(MAX_VID_RUN);

  typedef enum logic [1:0] {IDLE, GNT_GAME, GNT_VID} owner_t;

  owner_t     last_owner, next_owner;
  logic [3:0] vid_run_cnt;
  logic       game_gnt_c, vid_gnt_c;
  logic       game_oor, vid_oor, lock_hold;
  logic       game_rd_pend, vid_rd_pend, game_oor_pend, vid_oor_pend;
  logic [7:0] game_rdata_q, vid_rdata_q, game_rdata_c, vid_rdata_c;

  assign game_oor = {1'b0, bus.game_addr} >= DEPTH_LIM;
  assign vid_oor  = {1'b0, bus.vid_addr} >= DEPTH_LIM;

`ifdef GRID_ARB_LOCK_EN
  assign lock_hold = bus.game_lock && (last_owner == GNT_GAME);
`else
  assign lock_hold = 1'b0;
`endif

  // Grant decision and next owner; nothing is granted while in reset.
  always_comb begin
    game_gnt_c = 1'b0;
    vid_gnt_c  = 1'b0;
    next_owner = IDLE;
    if (!reset) begin
      if (bus.vid_req && !lock_hold &&
          !(bus.game_req && (vid_run_cnt == MAX_RUN))) begin
        vid_gnt_c  = 1'b1;
        next_owner = GNT_VID;
      end else if (bus.game_req) begin
        game_gnt_c = 1'b1;
        next_owner = GNT_GAME;
      end else if (lock_hold) begin
        // Keep ownership across idle cycles so the lock stays effective.
        next_owner = GNT_GAME;
      end
    end
  end

  // RAM drive and read-data return; rdata holds its last value between reads.
  always_comb begin
    bus.game_gnt  = game_gnt_c;
    bus.vid_gnt   = vid_gnt_c;
    bus.mem_addr  = game_gnt_c ? bus.game_addr : (vid_gnt_c ? bus.vid_addr : 8'h00);
    bus.mem_we    = game_gnt_c && bus.game_we && !game_oor;
    bus.mem_wdata = game_gnt_c ? bus.game_wdata : 8'h00;
    game_rdata_c  = game_rd_pend ? (game_oor_pend ? OOR_DATA : bus.mem_rdata) : game_rdata_q;
    vid_rdata_c   = vid_rd_pend ? (vid_oor_pend ? OOR_DATA : bus.mem_rdata) : vid_rdata_q;
    bus.game_rvalid = game_rd_pend && !reset;
    bus.vid_rvalid  = vid_rd_pend && !reset;
    bus.game_rdata  = reset ? 8'h00 : game_rdata_c;
    bus.vid_rdata   = reset ? 8'h00 : vid_rdata_c;
  end

  // Owner, starvation counter, read-pending flags and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner    <= IDLE;
      vid_run_cnt   <= 4'd0;
      game_rd_pend  <= 1'b0;
      vid_rd_pend   <= 1'b0;
      game_oor_pend <= 1'b0;
      vid_oor_pend  <= 1'b0;
      game_rdata_q  <= 8'h00;
      vid_rdata_q   <= 8'h00;
    end else begin
      last_owner <= next_owner;
      if (game_gnt_c || !bus.game_req)
        vid_run_cnt <= 4'd0;
      else if (vid_gnt_c && (vid_run_cnt != MAX_RUN))
        vid_run_cnt <= vid_run_cnt + 4'd1;
      game_rd_pend  <= game_gnt_c && !bus.game_we;
      vid_rd_pend   <= vid_gnt_c;
      game_oor_pend <= game_oor;
      vid_oor_pend  <= vid_oor;
      game_rdata_q  <= game_rdata_c;
      vid_rdata_q   <= vid_rdata_c;
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a 1-cycle synchronous RAM model.
// Build with GRID_ARB_LOCK_EN defined to also exercise game_lock.
module tb_grid_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ram [256];

  grid_mem_arbiter_if bus ();

  grid_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Grid RAM: read returns the pre-write contents one cycle later.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(8'h40 + i);
    bus.mem_rdata  = 8'h00;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_addr  = 8'h00;
    bus.game_wdata = 8'h00;
    bus.vid_req    = 1'b0;
    bus.vid_addr   = 8'h00;
`ifdef GRID_ARB_LOCK_EN
    bus.game_lock  = 1'b0;
`endif

    // Reset state, with requests pending to show they are not granted.
    reset = 1'b1;
    tick(); tick();
    bus.game_req = 1'b1; bus.vid_req = 1'b1; bus.game_addr = 8'd9; bus.vid_addr = 8'd7;
    settle();
    chk("rst_game_gnt", bus.game_gnt, 0);
    chk("rst_vid_gnt", bus.vid_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_game_rvalid", bus.game_rvalid, 0);
    chk("rst_vid_rvalid", bus.vid_rvalid, 0);
    chk("rst_game_rdata", bus.game_rdata, 0);
    chk("rst_vid_rdata", bus.vid_rdata, 0);
    tick();
    reset = 1'b0;
    bus.game_req = 1'b0; bus.vid_req = 1'b0;

    // Game write 17 <- 03, then read back.
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd17; bus.game_wdata = 8'h03;
    settle();
    chk("wr_game_gnt", bus.game_gnt, 1);
    chk("wr_vid_gnt", bus.vid_gnt, 0);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 17);
    chk("wr_mem_wdata", bus.mem_wdata, 8'h03);
    tick();
    bus.game_we = 1'b0;
    settle();
    chk("rd_game_gnt", bus.game_gnt, 1);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("wr_no_rvalid", bus.game_rvalid, 0);
    tick();
    bus.game_req = 1'b0;
    settle();
    chk("rd_rvalid", bus.game_rvalid, 1);
    chk("rd_rdata", bus.game_rdata, 8'h03);
    chk("rd_vid_rvalid", bus.vid_rvalid, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    tick();
    chk("rd_rvalid_drop", bus.game_rvalid, 0);
    chk("rd_rdata_hold", bus.game_rdata, 8'h03);

    // Starvation bound: 4 video grants, then game, then video again.
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd5;
    bus.vid_req = 1'b1; bus.vid_addr = 8'd10;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("run%0d_vid_gnt", i), bus.vid_gnt, 1);
      chk($sformatf("run%0d_game_gnt", i), bus.game_gnt, 0);
      chk($sformatf("run%0d_mem_addr", i), bus.mem_addr, 10);
      if (i > 0) chk($sformatf("run%0d_vid_rdata", i), bus.vid_rdata, 8'h4A);
      tick();
    end
    chk("run4_game_gnt", bus.game_gnt, 1);
    chk("run4_vid_gnt", bus.vid_gnt, 0);
    chk("run4_mem_addr", bus.mem_addr, 5);
    chk("run4_vid_rvalid", bus.vid_rvalid, 1);
    tick();
    chk("run5_vid_gnt", bus.vid_gnt, 1);
    chk("run5_game_gnt", bus.game_gnt, 0);
    chk("run5_game_rvalid", bus.game_rvalid, 1);
    chk("run5_game_rdata", bus.game_rdata, 8'h45);
    chk("run5_vid_rvalid", bus.vid_rvalid, 0);
    chk("run5_vid_rdata_hold", bus.vid_rdata, 8'h4A);
    bus.game_req = 1'b0;
    tick();
    bus.vid_req = 1'b0;
    tick();

    // Out-of-range write suppressed, out-of-range read returns border code.
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd252; bus.game_wdata = 8'h05;
    settle();
    chk("oor_wr_gnt", bus.game_gnt, 1);
    chk("oor_wr_mem_we", bus.mem_we, 0);
    tick();
    chk("oor_ram_untouched", ram[252], 8'h3C);
    bus.game_we = 1'b0; bus.game_addr = 8'd255;
    settle();
    chk("oor_rd_gnt", bus.game_gnt, 1);
    tick();
    bus.game_req = 1'b0;
    settle();
    chk("oor_rd_rvalid", bus.game_rvalid, 1);
    chk("oor_rd_rdata", bus.game_rdata, 8'h08);
    tick();

    // Back-to-back video reads of 0, 1, 2.
    bus.vid_req = 1'b1; bus.vid_addr = 8'd0;
    settle();
    chk("vb2b_gnt0", bus.vid_gnt, 1);
    tick();
    bus.vid_addr = 8'd1;
    settle();
    chk("vb2b_rvalid0", bus.vid_rvalid, 1);
    chk("vb2b_rdata0", bus.vid_rdata, 8'h40);
    tick();
    bus.vid_addr = 8'd2;
    settle();
    chk("vb2b_rvalid1", bus.vid_rvalid, 1);
    chk("vb2b_rdata1", bus.vid_rdata, 8'h41);
    chk("vb2b_game_rvalid", bus.game_rvalid, 0);
    tick();
    bus.vid_req = 1'b0;
    settle();
    chk("vb2b_rvalid2", bus.vid_rvalid, 1);
    chk("vb2b_rdata2", bus.vid_rdata, 8'h42);
    tick();
    chk("vb2b_rvalid_end", bus.vid_rvalid, 0);

    // Reset while a read is in flight.
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd3;
    settle();
    chk("mrst_gnt", bus.game_gnt, 1);
    tick();
    reset = 1'b1; bus.game_req = 1'b0;
    settle();
    chk("mrst_rvalid", bus.game_rvalid, 0);
    chk("mrst_rdata", bus.game_rdata, 0);
    chk("mrst_vid_rdata", bus.vid_rdata, 0);
    chk("mrst_gnt_low", bus.game_gnt, 0);
    tick();
    reset = 1'b0;
    settle();
    chk("mrst_after_rvalid", bus.game_rvalid, 0);
    bus.game_req = 1'b1; bus.game_addr = 8'd4;
    settle();
    chk("mrst_new_gnt", bus.game_gnt, 1);
    tick();
    bus.game_req = 1'b0;
    settle();
    chk("mrst_new_rvalid", bus.game_rvalid, 1);
    chk("mrst_new_rdata", bus.game_rdata, 8'h44);
    tick();

`ifdef GRID_ARB_LOCK_EN
    // Locked game ownership blocks video until the lock drops.
    bus.game_lock = 1'b1;
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd20; bus.game_wdata = 8'h07;
    settle();
    chk("lock_game_gnt", bus.game_gnt, 1);
    tick();
    bus.game_req = 1'b0; bus.vid_req = 1'b1; bus.vid_addr = 8'd30;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("lock%0d_vid_gnt", i), bus.vid_gnt, 0);
      tick();
    end
    bus.game_lock = 1'b0;
    settle();
    chk("unlock_vid_gnt", bus.vid_gnt, 1);
    tick();
    bus.vid_req = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
